// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle for the data-memory responder.
// The core drives the master modport; the memory responder uses the slave modport.
interface axi_lite_mem_slave_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport slave (
        input  axi_araddr, axi_arvalid, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport master (
        output axi_araddr, axi_arvalid, axi_rready,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder serving a word-addressed RAM with byte strobes.
// Independent read and write FSMs, one transaction outstanding on each.
module axi_lite_mem_slave #(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_lite_mem_slave_if.slave  bus,
    output logic [1:0]           w_state_dbg,
    output logic [1:0]           r_state_dbg
);
    // Handshake rule for every channel: a transfer happens at a posedge where
    // valid && ready; the sender holds valid and payload stable until then.

    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam int         CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    function automatic logic addr_hit(input logic [31:0] a);
        return a[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
    endfunction

    function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_BITS+1:2];
    endfunction

    logic [31:0] mem [DEPTH];

    // ---------------- write path ----------------
    w_state_t    w_state, w_state_n;
    logic [31:0] waddr_q, waddr_n, wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
    logic [1:0]  bresp_q, bresp_n;
    logic        commit;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    logic        aw_hs, w_hs;

    assign aw_hs = bus.axi_awvalid && awready_q;
    assign w_hs  = bus.axi_wvalid && wready_q;

    always_comb begin
        w_state_n = w_state;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        commit    = 1'b0;
        c_addr    = waddr_q;
        c_data    = wdata_q;
        c_strb    = wstrb_q;
        unique case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                wready_n  = 1'b1;
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_addr = bus.axi_awaddr;
                    c_data = bus.axi_wdata;
                    c_strb = bus.axi_wstrb;
                end else if (aw_hs) begin
                    waddr_n   = bus.axi_awaddr;
                    awready_n = 1'b0;
                    w_state_n = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wdata_n   = bus.axi_wdata;
                    wstrb_n   = bus.axi_wstrb;
                    wready_n  = 1'b0;
                    w_state_n = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = bus.axi_wdata;
                    c_strb = bus.axi_wstrb;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_addr = bus.axi_awaddr;
                end
            end
            W_RESP: begin
                if (bus.axi_bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        if (commit) begin
            w_state_n = W_RESP;
            awready_n = 1'b0;
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = addr_hit(c_addr) ? OKAY : DECERR;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state   <= W_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state   <= w_state_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    // RAM is deliberately not reset; misses never touch it.
    always_ff @(posedge clk) begin
        if (commit && addr_hit(c_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) mem[word_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t    r_state, r_state_n;
    logic [31:0] raddr_q, raddr_n;
    logic [CNT_W-1:0] rcnt_q, rcnt_n;
    logic        arready_q, arready_n, rvalid_q, rvalid_n;
    logic [31:0] rdata_q, rdata_n;
    logic [1:0]  rresp_q, rresp_n;
    logic        load;
    logic        ar_hs;

    assign ar_hs = bus.axi_arvalid && arready_q;

    // rdata is captured from the pre-edge RAM contents, so a write committed
    // on the same edge is not visible to this read.
    always_comb begin
        r_state_n = r_state;
        raddr_n   = raddr_q;
        rcnt_n    = rcnt_q;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        load      = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    raddr_n   = bus.axi_araddr;
                    arready_n = 1'b0;
                    if (READ_LATENCY <= 1) begin
                        r_state_n = R_RESP;
                    end else begin
                        r_state_n = R_WAIT;
                        rcnt_n    = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) begin
                    load      = 1'b1;
                    r_state_n = R_RESP;
                end else begin
                    rcnt_n = rcnt_q - 1'b1;
                end
            end
            R_RESP: begin
                // Entered with rvalid low only on the single-cycle path.
                if (!rvalid_q) begin
                    load = 1'b1;
                end else if (bus.axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        if (load) begin
            rvalid_n = 1'b1;
            rdata_n  = addr_hit(raddr_q) ? mem[word_idx(raddr_q)] : 32'h0;
            rresp_n  = addr_hit(raddr_q) ? OKAY : DECERR;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state   <= r_state_n;
            raddr_q   <= raddr_n;
            rcnt_q    <= rcnt_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
        end
    end

    assign bus.axi_awready = awready_q;
    assign bus.axi_wready  = wready_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.axi_arready = arready_q;
    assign bus.axi_rvalid  = rvalid_q;
    assign bus.axi_rdata   = rdata_q;
    assign bus.axi_rresp   = rresp_q;
    assign w_state_dbg     = w_state;
    assign r_state_dbg     = r_state;

    // Byte offset within a word carries no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.axi_awaddr[1:0], bus.axi_araddr[1:0]};
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench: two responders (read latency 1 and 3) share one stimulus;
// sel3 chooses whose outputs the tasks observe.
module tb_axi_lite_mem_slave;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit sel3 = 1'b0;

    axi_lite_mem_slave_if bus ();
    axi_lite_mem_slave_if bus3 ();
    logic [1:0] w_dbg, r_dbg, w_dbg3, r_dbg3;

    assign bus3.axi_araddr  = bus.axi_araddr;
    assign bus3.axi_arvalid = bus.axi_arvalid;
    assign bus3.axi_rready  = bus.axi_rready;
    assign bus3.axi_awaddr  = bus.axi_awaddr;
    assign bus3.axi_awvalid = bus.axi_awvalid;
    assign bus3.axi_wdata   = bus.axi_wdata;
    assign bus3.axi_wstrb   = bus.axi_wstrb;
    assign bus3.axi_wvalid  = bus.axi_wvalid;
    assign bus3.axi_bready  = bus.axi_bready;

    axi_lite_mem_slave #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave), .w_state_dbg(w_dbg), .r_state_dbg(r_dbg));
    axi_lite_mem_slave #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3.slave), .w_state_dbg(w_dbg3), .r_state_dbg(r_dbg3));

    wire        o_arready = sel3 ? bus3.axi_arready : bus.axi_arready;
    wire        o_rvalid  = sel3 ? bus3.axi_rvalid  : bus.axi_rvalid;
    wire [31:0] o_rdata   = sel3 ? bus3.axi_rdata   : bus.axi_rdata;
    wire [1:0]  o_rresp   = sel3 ? bus3.axi_rresp   : bus.axi_rresp;
    wire        o_awready = sel3 ? bus3.axi_awready : bus.axi_awready;
    wire        o_wready  = sel3 ? bus3.axi_wready  : bus.axi_wready;
    wire        o_bvalid  = sel3 ? bus3.axi_bvalid  : bus.axi_bvalid;
    wire [1:0]  o_bresp   = sel3 ? bus3.axi_bresp   : bus.axi_bresp;

    // Driver: AW and W presented together; returns bresp and the number of
    // sampled cycles after the final data handshake until bvalid was seen.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int bcyc);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int n = 0;
        bus.axi_awaddr = a; bus.axi_wdata = d; bus.axi_wstrb = s;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = !aw_done && o_awready;
            w_go  = !w_done && o_wready;
            @(posedge clk);
            n++;
            if (aw_go) aw_done = 1'b1;
            if (w_go) w_done = 1'b1;
            @(negedge clk);
            if (aw_done) bus.axi_awvalid = 1'b0;
            if (w_done) bus.axi_wvalid = 1'b0;
        end
        bcyc = 1;
        while (!o_bvalid && bcyc < 20) begin
            @(posedge clk); @(negedge clk); bcyc++;
        end
        checks++;
        if (!o_bvalid) begin
            failures++;
            $display("FAIL write_timeout addr=%h got bvalid=%b expected 1", a, o_bvalid);
        end
        resp = o_bresp;
        @(posedge clk); @(negedge clk);
    endtask

    // Driver: returns rdata, rresp and edges from AR handshake to rvalid.
    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit done = 0;
        int n = 0;
        bus.axi_araddr = a; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b1;
        while (!done && n < 20) begin
            done = o_arready;
            @(posedge clk); n++;
            @(negedge clk);
        end
        bus.axi_arvalid = 1'b0;
        lat = 0;
        while (!o_rvalid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (!o_rvalid) begin
            failures++;
            $display("FAIL read_timeout addr=%h got rvalid=%b expected 1", a, o_rvalid);
        end
        data = o_rdata; resp = o_rresp;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.axi_araddr = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b1;
        bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0; bus.axi_wdata = '0;
        bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0; bus.axi_bready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_readies got %b expected 000", {o_arready, o_awready, o_wready});
        end
        checks++;
        if ({bus.axi_rvalid, bus.axi_bvalid, bus3.axi_rvalid, bus3.axi_bvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valids got %b expected 0000",
                     {bus.axi_rvalid, bus.axi_bvalid, bus3.axi_rvalid, bus3.axi_bvalid});
        end
        checks++;
        if ({o_rdata, o_rresp, o_bresp} !== 36'h0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b expected 0", o_rdata, o_rresp, o_bresp);
        end
        rstn = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_readies got %b expected 111", {o_arready, o_awready, o_wready});
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] r; logic [31:0] d; int bc, lat;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, r, bc);
        checks++;
        if (r !== 2'b00 || bc !== 1) begin
            failures++;
            $display("FAIL simul_write got bresp=%b bcyc=%0d expected 00/1", r, bc);
        end
        do_read(32'h10, d, r, lat);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 1) begin
            failures++;
            $display("FAIL simul_read got %h/%b lat=%0d expected deadbeef/00 lat=1", d, r, lat);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r; logic [31:0] d; int bc, lat;
        do_write(32'h20, 32'h11223344, 4'hF, r, bc);
        bus.axi_wdata = 32'h00AA0000; bus.axi_wstrb = 4'b0100; bus.axi_wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_wready !== 1'b0 || o_awready !== 1'b1) begin
                failures++;
                $display("FAIL wfirst_wait%0d got wready=%b awready=%b expected 0/1", i, o_wready, o_awready);
            end
            if (i == 0) begin
                @(posedge clk); @(negedge clk);
            end
        end
        bus.axi_awaddr = 32'h20; bus.axi_awvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_awvalid = 1'b0;
        checks++;
        if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
            failures++;
            $display("FAIL wfirst_b got bvalid=%b bresp=%b expected 1/00", o_bvalid, o_bresp);
        end
        @(posedge clk); @(negedge clk);
        do_read(32'h20, d, r, lat);
        checks++;
        if (d !== 32'h11AA3344 || r !== 2'b00) begin
            failures++;
            $display("FAIL wfirst_read got %h/%b expected 11aa3344/00", d, r);
        end
    endtask

    task automatic test_aw_first_stall();
        logic [1:0] r; logic [31:0] d; int lat;
        bus.axi_bready = 1'b0;
        bus.axi_awaddr = 32'h30; bus.axi_awvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_awvalid = 1'b0;
        checks++;
        if (o_awready !== 1'b0 || o_wready !== 1'b1 || w_dbg !== 2'd1) begin
            failures++;
            $display("FAIL awfirst_wait got awready=%b wready=%b state=%0d expected 0/1/1", o_awready, o_wready, w_dbg);
        end
        bus.axi_wdata = 32'hCAFEF00D; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_wvalid = 1'b0;
        bus.axi_awaddr = 32'h34; bus.axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_bvalid !== 1'b1 || o_bresp !== 2'b00 || o_awready !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d got bvalid=%b bresp=%b awready=%b expected 1/00/0", i, o_bvalid, o_bresp, o_awready);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.axi_bready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (o_bvalid !== 1'b0 || o_awready !== 1'b1 || o_wready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got bvalid=%b awready=%b wready=%b expected 0/1/1", o_bvalid, o_awready, o_wready);
        end
        bus.axi_wdata = 32'h5555AAAA; bus.axi_wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        checks++;
        if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
            failures++;
            $display("FAIL second_aw_b got bvalid=%b bresp=%b expected 1/00", o_bvalid, o_bresp);
        end
        @(posedge clk); @(negedge clk);
        do_read(32'h30, d, r, lat);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL awfirst_read got %h expected cafef00d", d);
        end
        do_read(32'h34, d, r, lat);
        checks++;
        if (d !== 32'h5555AAAA) begin
            failures++;
            $display("FAIL second_aw_read got %h expected 5555aaaa", d);
        end
    endtask

    task automatic test_decode();
        logic [1:0] r; logic [31:0] d; int bc, lat;
        do_write(32'h0, 32'hA5A5A5A5, 4'hF, r, bc);
        do_write(32'h1000, 32'h12345678, 4'hF, r, bc);
        checks++;
        if (r !== 2'b11) begin
            failures++;
            $display("FAIL miss_write_bresp got %b expected 11", r);
        end
        do_read(32'h0, d, r, lat);
        checks++;
        if (d !== 32'hA5A5A5A5 || r !== 2'b00) begin
            failures++;
            $display("FAIL miss_ram_unchanged got %h/%b expected a5a5a5a5/00", d, r);
        end
        do_read(32'h1000, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b11) begin
            failures++;
            $display("FAIL miss_read got %h/%b expected 00000000/11", d, r);
        end
        do_write(32'h10, 32'hFFFFFFFF, 4'h0, r, bc);
        checks++;
        if (r !== 2'b00) begin
            failures++;
            $display("FAIL zero_strb_bresp got %b expected 00", r);
        end
        do_read(32'h10, d, r, lat);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL zero_strb_read got %h expected deadbeef", d);
        end
        do_write(32'hFFF, 32'h600DCAFE, 4'hF, r, bc);
        do_read(32'hFFC, d, r, lat);
        checks++;
        if (d !== 32'h600DCAFE || r !== 2'b00) begin
            failures++;
            $display("FAIL top_word got %h/%b expected 600dcafe/00", d, r);
        end
    endtask

    task automatic test_latency();
        logic [1:0] r; logic [31:0] d; int bc, lat; bit b_seen;
        do_write(32'h40, 32'h0BADF00D, 4'hF, r, bc);
        repeat (8) @(negedge clk);
        sel3 = 1'b1;
        bus.axi_araddr = 32'h40; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b0;
        bus.axi_awaddr = 32'h44; bus.axi_wdata = 32'h77778888; bus.axi_wstrb = 4'hF;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b1;
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b111) begin
            failures++;
            $display("FAIL lat_idle_readies got %b expected 111", {o_arready, o_awready, o_wready});
        end
        @(posedge clk); @(negedge clk);
        bus.axi_arvalid = 1'b0; bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        b_seen = o_bvalid;
        lat = 0;
        while (!o_rvalid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
            if (o_bvalid) b_seen = 1'b1;
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL lat3_rvalid got %0d edges expected 3", lat);
        end
        checks++;
        if (b_seen !== 1'b1) begin
            failures++;
            $display("FAIL lat3_concurrent_write got bvalid_seen=%b expected 1", b_seen);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_rvalid !== 1'b1 || o_rdata !== 32'h0BADF00D || o_rresp !== 2'b00) begin
                failures++;
                $display("FAIL rready_stall%0d got %b/%h/%b expected 1/0badf00d/00", i, o_rvalid, o_rdata, o_rresp);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.axi_rready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1) begin
            failures++;
            $display("FAIL rready_release got rvalid=%b arready=%b expected 0/1", o_rvalid, o_arready);
        end
        do_read(32'h44, d, r, lat);
        checks++;
        if (d !== 32'h77778888 || lat !== 3) begin
            failures++;
            $display("FAIL lat3_read2 got %h lat=%0d expected 77778888 lat=3", d, lat);
        end
    endtask

    task automatic test_reset_mid();
        bit any_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.axi_awaddr = 32'h50; bus.axi_awvalid = 1'b1;
        bus.axi_araddr = 32'h40; bus.axi_arvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.axi_awvalid = 1'b0; bus.axi_arvalid = 1'b0;
        checks++;
        if (w_dbg3 !== 2'd1 || r_dbg3 !== 2'd1) begin
            failures++;
            $display("FAIL mid_states got w=%0d r=%0d expected 1/1", w_dbg3, r_dbg3);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus3.axi_arready, bus3.axi_awready, bus3.axi_wready, bus3.axi_rvalid, bus3.axi_bvalid,
             bus.axi_rvalid, bus.axi_bvalid} !== 7'b0) begin
            failures++;
            $display("FAIL mid_reset_async got %b expected 0000000",
                     {bus3.axi_arready, bus3.axi_awready, bus3.axi_wready, bus3.axi_rvalid, bus3.axi_bvalid,
                      bus.axi_rvalid, bus.axi_bvalid});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b111) begin
            failures++;
            $display("FAIL mid_release_readies got %b expected 111", {o_arready, o_awready, o_wready});
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.axi_rvalid || bus.axi_bvalid || bus3.axi_rvalid || bus3.axi_bvalid) any_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (any_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_response got valid_seen=%b expected 0", any_valid);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_w_first();
        test_aw_first_stall();
        test_decode();
        test_latency();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
